mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store unit that produces the data-memory read word consumed by the write-back result mux, and drives the data-memory bus for stores. It sits between the EX/MEM pipeline register and the data memory. It converts one load or store per instruction into a valid/ready bus request followed by a response. It aligns and extends load data, generates byte strobes for stores, and stalls the pipeline until the access completes.

## Interface
- DATA_WIDTH, 32, data bus and register width; only 32 is supported.
- DATA_ADDR_WIDTH, 32, byte address width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read_EX_MEM_o  in  1  instruction is a load.
- mem_write_EX_MEM_o  in  1  instruction is a store; never asserted together with mem_read.
- funct3_EX_MEM_o  in  3  RISC-V width code: 0=B, 1=H, 2=W, 4=BU, 5=HU. Stores use 0, 1 and 2 only.
- alu_res_EX_MEM_o  in  DATA_ADDR_WIDTH  byte address.
- rs2_data_EX_MEM_o  in  DATA_WIDTH  store data, right-aligned.
- dmem_req_valid  out  1  bus request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_req_we  out  1  1 = write.
- dmem_req_addr  out  DATA_ADDR_WIDTH  word address, with addr[1:0] forced to 0.
- dmem_req_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_req_wstrb  out  4  byte-enable mask.
- dmem_resp_valid  in  1  response (read data or write ack) valid.
- dmem_resp_rdata  in  DATA_WIDTH  raw read word.
- data_mem_rdata_MEM  out  DATA_WIDTH  aligned and extended load result.
- stall_MEM  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers and the MEM/WB register.
- mem_fault_MEM  out  1  misaligned or illegal-width access.

## Operation
- A memory operation is present when start = mem_read | mem_write.
- Fault check happens in IDLE, combinationally. The access faults when:
  - H/HU loads or stores have addr[0]=1;
  - W accesses have addr[1:0]≠0;
  - funct3 is 3, 6 or 7, or a store has funct3 of 4 or 5.
- On a fault: mem_fault_MEM=1 for that cycle, stall_MEM=0, no bus request, data_mem_rdata_MEM=0.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: on start with no fault, register the request fields and the byte offset, then go to REQ; stall_MEM=1 in this cycle.
  - REQ: hold dmem_req_valid=1 with all request fields stable. On dmem_req_ready=1, go to RESP.
  - RESP: wait for dmem_resp_valid. Ignore dmem_resp_valid in any other state. On a response, capture the processed load data and go to DONE.
  - DONE: stall_MEM=0 and data_mem_rdata_MEM is valid. The pipeline advances at the end of this cycle. The next state is IDLE unconditionally; DONE never starts a new access.
- stall_MEM = (IDLE & start & ~fault) | REQ | RESP.
- Store formatting, with off = addr[1:0]:
  - SB: wdata = {4{byte}}, wstrb = 4'b0001 << off.
  - SH: wdata = {2{half}}, wstrb = 4'b0011 << off.
  - SW: wdata = rs2, wstrb = 4'b1111.
- Loads set wstrb=0.
- Load formatting: shift the raw word right by off*8.
  - B sign-extends bit 7; BU zero-extends.
  - H sign-extends bit 15; HU zero-extends.
  - W passes the word through.
- A store's response data is ignored, and data_mem_rdata_MEM=0 in DONE.
- data_mem_rdata_MEM holds its last value outside DONE.

## Timing
- Reset values: state=IDLE, dmem_req_valid=0, dmem_req_we=0, dmem_req_addr=0, dmem_req_wdata=0, dmem_req_wstrb=0, data_mem_rdata_MEM=0, mem_fault_MEM=0.
- stall_MEM=0 during reset.
- Minimum access latency is 4 cycles (T..T+3), with ready=1 at T+1 and resp_valid at T+2:
  - T: IDLE, start seen, stall=1.
  - T+1: REQ, request accepted.
  - T+2: RESP, response captured.
  - T+3: DONE, stall=0.
- Each cycle of ready=0 or resp_valid=0 adds one cycle.
- Non-memory instructions and faulting accesses take 0 stall cycles.
- The request fields must not change while dmem_req_valid=1 and ready=0.
- Reset asserted mid-access (in REQ or RESP) aborts the access immediately. Later responses are ignored because the state is IDLE.

## Test plan
- SW addr 0x104, rs2 0xDEADBEEF, ready=1, resp the next cycle -> one request with addr 0x104, wstrb 1111, wdata 0xDEADBEEF; stall high exactly 3 cycles.
- LB addr 0x103, raw word 0x80FF1234 -> data_mem_rdata_MEM=0xFFFFFF80 in DONE. LBU at the same address -> 0x00000080.
- SH addr 0x202, rs2 0x0000ABCD -> addr 0x200, wstrb 1100, wdata 0xABCDABCD.
- LW addr 0x301 -> mem_fault_MEM=1 for one cycle, no dmem_req_valid, stall_MEM=0.
- LHU addr 0x10, ready held low for 3 cycles, then resp after 2 more cycles with raw word 0x0000F00D -> request fields stable throughout, stall for 7 cycles, result 0x0000F00D.
- Reset asserted while in RESP, then resp_valid pulses -> all outputs return to reset values, no DONE cycle, and data_mem_rdata_MEM stays 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store unit. Turns one load or store from the EX/MEM
//   register into a valid/ready request on the data-memory bus followed by a
//   response, formats store data/strobes, aligns and extends load data, and
//   stalls the pipeline until the access completes.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   mem_read_EX_MEM_o     instruction is a load
//   mem_write_EX_MEM_o    instruction is a store
//   funct3_EX_MEM_o       width code (B/H/W/BU/HU)
//   alu_res_EX_MEM_o      byte address
//   rs2_data_EX_MEM_o     right-aligned store data
//   dmem_req_*            request channel (valid/ready, we, addr, wdata, wstrb)
//   dmem_resp_*           response channel (valid, raw read word)
//   data_mem_rdata_MEM    aligned/extended load result, valid in DONE
//   stall_MEM             pipeline freeze while an access is in flight
//   mem_fault_MEM         misaligned or illegal-width access (single cycle)
module mem_access_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read_EX_MEM_o,
  input  logic                       mem_write_EX_MEM_o,
  input  logic [2:0]                 funct3_EX_MEM_o,
  input  logic [DATA_ADDR_WIDTH-1:0] alu_res_EX_MEM_o,
  input  logic [DATA_WIDTH-1:0]      rs2_data_EX_MEM_o,
  output logic                       dmem_req_valid,
  input  logic                       dmem_req_ready,
  output logic                       dmem_req_we,
  output logic [DATA_ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0]      dmem_req_wdata,
  output logic [3:0]                 dmem_req_wstrb,
  input  logic                       dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]      dmem_resp_rdata,
  output logic [DATA_WIDTH-1:0]      data_mem_rdata_MEM,
  output logic                       stall_MEM,
  output logic                       mem_fault_MEM
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t                 state, state_next;
  logic                   start, fault, launch;
  logic [1:0]             off;
  logic [DATA_WIDTH-1:0]  fmt_wdata;
  logic [3:0]             fmt_wstrb;

  logic                   load_q;
  logic [2:0]             funct3_q;
  logic [1:0]             off_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]  load_data;

  assign start  = mem_read_EX_MEM_o | mem_write_EX_MEM_o;
  assign off    = alu_res_EX_MEM_o[1:0];
  assign launch = (state == IDLE) && start && !fault;

  always_comb begin
    fault = 1'b0;
    case (funct3_EX_MEM_o)
      3'd0:    fault = 1'b0;
      3'd1:    fault = off[0];
      3'd2:    fault = |off;
      3'd4:    fault = mem_write_EX_MEM_o;
      3'd5:    fault = mem_write_EX_MEM_o | off[0];
      default: fault = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the strobes alone select the bytes.
  always_comb begin
    fmt_wdata = '0;
    fmt_wstrb = '0;
    if (mem_write_EX_MEM_o) begin
      case (funct3_EX_MEM_o[1:0])
        2'd0: begin
          fmt_wdata = {4{rs2_data_EX_MEM_o[7:0]}};
          fmt_wstrb = 4'b0001 << off;
        end
        2'd1: begin
          fmt_wdata = {2{rs2_data_EX_MEM_o[15:0]}};
          fmt_wstrb = 4'b0011 << off;
        end
        default: begin
          fmt_wdata = rs2_data_EX_MEM_o;
          fmt_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    shifted   = dmem_resp_rdata >> {off_q, 3'b000};
    load_data = shifted;
    case (funct3_q)
      3'd0:    load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'd4:    load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'd1:    load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'd5:    load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = REQ;
      REQ:     if (dmem_req_ready) state_next = RESP;
      RESP:    if (dmem_resp_valid) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      dmem_req_wstrb <= '0;
      load_q         <= 1'b0;
      funct3_q       <= '0;
      off_q          <= '0;
      rdata_q        <= '0;
    end else begin
      if (launch) begin
        dmem_req_we    <= mem_write_EX_MEM_o;
        dmem_req_addr  <= {alu_res_EX_MEM_o[DATA_ADDR_WIDTH-1:2], 2'b00};
        dmem_req_wdata <= fmt_wdata;
        dmem_req_wstrb <= fmt_wstrb;
        load_q         <= mem_read_EX_MEM_o;
        funct3_q       <= funct3_EX_MEM_o;
        off_q          <= off;
      end
      if (state == RESP && dmem_resp_valid)
        rdata_q <= load_q ? load_data : '0;
    end
  end

  assign dmem_req_valid     = (state == REQ);
  // Fault and stall are combinational and gated by rst so both read 0 in reset.
  assign mem_fault_MEM      = !rst && (state == IDLE) && start && fault;
  assign stall_MEM          = !rst && (launch || state == REQ || state == RESP);
  assign data_mem_rdata_MEM = mem_fault_MEM ? '0 : rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural reference model.
module tb_mem_access_unit;

  logic        clk, rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_res, rs2_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata, data_mem_rdata;
  logic        stall, fault;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Expectations shared with the compare process.
  bit          exp_req_ok = 0;
  bit          exp_we     = 0;
  logic [31:0] exp_addr   = '0;
  logic [31:0] exp_wdata  = '0;
  logic [3:0]  exp_wstrb  = '0;
  logic [31:0] last_rd    = '0;

  mem_access_unit #(.DATA_WIDTH(32), .DATA_ADDR_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem_read_EX_MEM_o  (mem_read),
    .mem_write_EX_MEM_o (mem_write),
    .funct3_EX_MEM_o    (funct3),
    .alu_res_EX_MEM_o   (alu_res),
    .rs2_data_EX_MEM_o  (rs2_data),
    .dmem_req_valid     (dmem_req_valid),
    .dmem_req_ready     (dmem_req_ready),
    .dmem_req_we        (dmem_req_we),
    .dmem_req_addr      (dmem_req_addr),
    .dmem_req_wdata     (dmem_req_wdata),
    .dmem_req_wstrb     (dmem_req_wstrb),
    .dmem_resp_valid    (dmem_resp_valid),
    .dmem_resp_rdata    (dmem_resp_rdata),
    .data_mem_rdata_MEM (data_mem_rdata),
    .stall_MEM          (stall),
    .mem_fault_MEM      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_bytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_fault(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (wr && f3 >= 4) return 1'b1;
    return (a % m_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_addr(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  function automatic logic [3:0] m_wstrb(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int unsigned mask;
    if (!wr) return 4'd0;
    mask = ((1 << m_bytes(f3)) - 1) << (a % 4);
    return 4'(mask);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    case (m_bytes(f3))
      1:       return (rs2 & 32'hFF) * 32'h01010101;
      2:       return (rs2 & 32'hFFFF) * 32'h00010001;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] raw, input logic [31:0] a);
    longint v;
    longint span;
    int unsigned nb;
    nb = m_bytes(f3);
    v  = longint'(raw) >> (8 * (a % 4));
    if (nb < 4) begin
      span = 64'sd1 << (8 * nb);
      v    = v % span;
      if (f3 < 4 && v >= span / 2) v = v - span;
    end
    return 32'(v);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("rst_valid", 32'(dmem_req_valid), 32'd0);
      check("rst_we",    32'(dmem_req_we), 32'd0);
      check("rst_addr",  dmem_req_addr, 32'd0);
      check("rst_wdata", dmem_req_wdata, 32'd0);
      check("rst_wstrb", 32'(dmem_req_wstrb), 32'd0);
      check("rst_rdata", data_mem_rdata, 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
    end else if (dmem_req_valid) begin
      check("req_allowed", 32'(dmem_req_valid), 32'(exp_req_ok));
      if (exp_req_ok) begin
        check("req_addr",  dmem_req_addr, exp_addr);
        check("req_we",    32'(dmem_req_we), 32'(exp_we));
        check("req_wstrb", 32'(dmem_req_wstrb), 32'(exp_wstrb));
        if (exp_we) check("req_wdata", dmem_req_wdata, exp_wdata);
      end
    end
  end

  // ---------------- directed transaction driver ----------------
  task automatic run_txn(input string name, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] raw,
                         input int unsigned rdy_d, input int unsigned rsp_d,
                         output int unsigned stalls);
    bit          go, flt, accepted, done;
    int unsigned accepts, rdy_wait, rsp_wait, exp_stall;
    logic [31:0] exp_data;
    go         = rd | wr;
    flt        = go && m_fault(wr, f3, a);
    exp_req_ok = go && !flt;
    exp_we     = wr;
    exp_addr   = m_addr(a);
    exp_wstrb  = m_wstrb(wr, f3, a);
    exp_wdata  = m_wdata(f3, rs2);
    exp_stall  = exp_req_ok ? 3 + rdy_d + rsp_d : 0;
    if (exp_req_ok)  exp_data = rd ? m_load(f3, raw, a) : 32'd0;
    else if (flt)    exp_data = 32'd0;
    else             exp_data = last_rd;
    stalls = 0; accepts = 0; rdy_wait = 0; rsp_wait = 0; accepted = 0; done = 0;

    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; alu_res = a; rs2_data = rs2;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      if (!stall) begin
        done = 1;
      end else begin
        stalls++;
        if (dmem_req_valid) begin
          if (rdy_wait == rdy_d) begin
            dmem_req_ready = 1'b1;
            accepts++;
            accepted = 1;
          end else rdy_wait++;
        end else if (accepted) begin
          if (rsp_wait == rsp_d) begin
            dmem_resp_valid = 1'b1;
            dmem_resp_rdata = raw;
          end else rsp_wait++;
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: stall still high after 64 cycles, expected release", name);
    end
    check({name, "_stall_cycles"}, stalls, exp_stall);
    check({name, "_accepts"}, accepts, exp_req_ok ? 32'd1 : 32'd0);
    check({name, "_fault"}, 32'(fault), 32'(flt));
    check({name, "_rdata"}, data_mem_rdata, exp_data);
    check({name, "_valid_low"}, 32'(dmem_req_valid), 32'd0);
    if (exp_req_ok) last_rd = exp_data;

    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check({name, "_fault_after"}, 32'(fault), 32'd0);
    check({name, "_stall_after"}, 32'(stall), 32'd0);
    check({name, "_rdata_hold"}, data_mem_rdata, last_rd);
  endtask

  int unsigned st;

  initial begin
    rst = 1'b1;
    mem_read = 0; mem_write = 0; funct3 = 0; alu_res = 0; rs2_data = 0;
    dmem_req_ready = 0; dmem_resp_valid = 0; dmem_resp_rdata = 0;

    // Pin the model against hand-computed values.
    check("pin_sh_wstrb", 32'(m_wstrb(1'b1, 3'd1, 32'h202)), 32'h0000000C);
    check("pin_sh_wdata", m_wdata(3'd1, 32'h0000ABCD), 32'hABCDABCD);
    check("pin_sh_addr",  m_addr(32'h202), 32'h00000200);
    check("pin_lb_data",  m_load(3'd0, 32'h80FF1234, 32'h103), 32'hFFFFFF80);
    check("pin_lbu_data", m_load(3'd4, 32'h80FF1234, 32'h103), 32'h00000080);
    check("pin_lw_fault", 32'(m_fault(1'b0, 3'd2, 32'h301)), 32'd1);

    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    run_txn("sw",   0, 1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, st);
    check("sw_stall_literal", st, 32'd3);
    run_txn("lb",   1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 0, 0, st);
    check("lb_literal", data_mem_rdata, 32'hFFFFFF80);
    run_txn("lbu",  1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 0, 0, st);
    check("lbu_literal", data_mem_rdata, 32'h00000080);
    run_txn("sh",   0, 1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 1, 0, st);
    run_txn("lw_mis", 1, 0, 3'd2, 32'h301, 32'h0, 32'h0, 0, 0, st);
    run_txn("sb",   0, 1, 3'd0, 32'h007, 32'h123456A5, 32'h0, 0, 1, st);
    run_txn("lh",   1, 0, 3'd1, 32'h102, 32'h0, 32'h8001_5555, 0, 0, st);
    run_txn("lh0",  1, 0, 3'd1, 32'h100, 32'h0, 32'h1234_7FFF, 0, 0, st);
    run_txn("lw",   1, 0, 3'd2, 32'h0C0, 32'h0, 32'hCAFEF00D, 1, 1, st);
    run_txn("sh_mis", 0, 1, 3'd1, 32'h201, 32'h1111, 32'h0, 0, 0, st);
    run_txn("sbu_bad", 0, 1, 3'd4, 32'h200, 32'h1111, 32'h0, 0, 0, st);
    run_txn("f3_bad", 1, 0, 3'd3, 32'h200, 32'h0, 32'h0, 0, 0, st);
    run_txn("nop",  0, 0, 3'd2, 32'h123, 32'h0, 32'h0, 0, 0, st);
    run_txn("lhu",  1, 0, 3'd5, 32'h010, 32'h0, 32'h0000F00D, 2, 2, st);
    check("lhu_stall_literal", st, 32'd7);
    check("lhu_literal", data_mem_rdata, 32'h0000F00D);

    // Reset while waiting for a response: access is dropped, later response ignored.
    exp_req_ok = 1; exp_we = 0; exp_addr = 32'h400; exp_wstrb = 4'd0;
    @(posedge clk); #1;
    mem_read = 1; funct3 = 3'd2; alu_res = 32'h400;
    @(negedge clk);                       // IDLE, start seen
    @(negedge clk);                       // REQ
    dmem_req_ready = 1'b1;
    @(negedge clk);                       // RESP
    dmem_req_ready = 1'b0;
    check("rst_test_in_resp", 32'(stall), 32'd1);
    #1 rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_resp_valid = 1'b0;
      check("post_rst_stall", 32'(stall), 32'd0);
      check("post_rst_valid", 32'(dmem_req_valid), 32'd0);
      check("post_rst_rdata", data_mem_rdata, 32'd0);
      check("post_rst_addr",  dmem_req_addr, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
